comp_mag_sqrd_acc: RTL

Parametrised multi-channel complex-to-power stage with integration. It takes a time-multiplexed stream of interleaved signed real/imag samples from NCH channels and forms re²+im² per complex sample. It then accumulates acc_len consecutive samples per channel and emits one saturated power value per channel per integration block. It sits after the channelizer/DDC output and feeds detection and averaging logic.

---
 rtl/comp_mag_sqrd_acc.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/comp_mag_sqrd_acc.sv
// Multi-channel re^2+im^2 power with per-channel integration over len samples and saturation.
// 2-cycle latency from final im beat to valid_o; no backpressure, one beat per cycle sustained.
module comp_mag_sqrd_acc #(
    parameter int DW        = 16,
    parameter int NCH       = 2,
    parameter int ACC_LEN_W = 4,
    parameter int OW        = 2*DW+ACC_LEN_W,
    parameter int CHW       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DW-1:0]        data_i,
    input  logic                 valid_i,
    input  logic                 last_i,
    input  logic [ACC_LEN_W-1:0] acc_len_i,
    output logic [OW-1:0]        mag_sqrd_o,
    output logic [CHW-1:0]       ch_o,
    output logic                 valid_o,
    output logic                 last_o,
    output logic                 sat_o,
    output logic                 sync_err_o
);
    localparam int MW = 2*DW + 1;
    localparam int SW = ((OW > MW) ? OW : MW) + 1;
    localparam logic [CHW-1:0] LAST_CH = CHW'(NCH - 1);
    localparam logic [SW-1:0]  SAT_MAX = {{(SW-OW){1'b0}}, {OW{1'b1}}};

    // input beat tracking
    logic           phase;
    logic [CHW-1:0] ch;
    logic           frame_end;
    logic           beat_err;

    // stage 1
    logic                 s1_vld;
    logic                 s1_err;
    logic                 s1_phase;
    logic [CHW-1:0]       s1_ch;
    logic signed [DW-1:0] s1_dat;
    logic [ACC_LEN_W-1:0] s1_acc_len;

    // stage 2 state
    logic [2*DW-1:0]      re_sq;
    logic [OW-1:0]        acc [NCH];
    logic [ACC_LEN_W-1:0] cnt [NCH];
    logic [NCH-1:0]       sat_seen;
    logic [ACC_LEN_W-1:0] len;

    logic signed [2*DW-1:0] sq;
    logic [MW-1:0]          mag;
    logic [SW-1:0]          sum;
    logic                   over;
    logic [OW-1:0]          clamp;
    logic                   block_done;
    logic [ACC_LEN_W-1:0]   len_nxt;

    assign frame_end = phase && (ch == LAST_CH);
    assign beat_err  = last_i != frame_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase      <= 1'b0;
            ch         <= '0;
            s1_vld     <= 1'b0;
            s1_err     <= 1'b0;
            s1_phase   <= 1'b0;
            s1_ch      <= '0;
            s1_dat     <= '0;
            s1_acc_len <= '0;
        end else begin
            s1_vld <= valid_i;
            if (valid_i) begin
                s1_err     <= beat_err;
                s1_phase   <= phase;
                s1_ch      <= ch;
                s1_dat     <= data_i;
                s1_acc_len <= acc_len_i;
                if (beat_err || frame_end) begin
                    phase <= 1'b0;
                    ch    <= '0;
                end else if (!phase) begin
                    phase <= 1'b1;
                end else begin
                    phase <= 1'b0;
                    ch    <= ch + 1'b1;
                end
            end
        end
    end

    always_comb begin
        sq         = s1_dat * s1_dat;
        mag        = {1'b0, re_sq} + {1'b0, sq};
        sum        = SW'(acc[s1_ch]) + SW'(mag);
        over       = sum > SAT_MAX;
        clamp      = over ? SAT_MAX[OW-1:0] : sum[OW-1:0];
        block_done = cnt[s1_ch] == (len - ACC_LEN_W'(1));
        len_nxt    = (s1_acc_len == '0) ? ACC_LEN_W'(1) : s1_acc_len;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            re_sq      <= '0;
            sat_seen   <= '0;
            len        <= ACC_LEN_W'(1);
            valid_o    <= 1'b0;
            sync_err_o <= 1'b0;
            mag_sqrd_o <= '0;
            ch_o       <= '0;
            last_o     <= 1'b0;
            sat_o      <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                acc[i] <= '0;
                cnt[i] <= '0;
            end
        end else begin
            valid_o    <= 1'b0;
            sync_err_o <= 1'b0;
            if (s1_vld && s1_err) begin
                // framing loss: drop the beat and restart every channel from scratch
                sync_err_o <= 1'b1;
                re_sq      <= '0;
                sat_seen   <= '0;
                for (int i = 0; i < NCH; i++) begin
                    acc[i] <= '0;
                    cnt[i] <= '0;
                end
            end else if (s1_vld && !s1_phase) begin
                re_sq <= sq;
                if (s1_ch == '0 && cnt[0] == '0)
                    len <= len_nxt;
            end else if (s1_vld) begin
                if (block_done) begin
                    valid_o         <= 1'b1;
                    mag_sqrd_o      <= clamp;
                    ch_o            <= s1_ch;
                    last_o          <= s1_ch == LAST_CH;
                    sat_o           <= over || sat_seen[s1_ch];
                    acc[s1_ch]      <= '0;
                    cnt[s1_ch]      <= '0;
                    sat_seen[s1_ch] <= 1'b0;
                end else begin
                    // clamped value keeps accumulating; sticky flag remembers the clamp
                    acc[s1_ch]      <= clamp;
                    cnt[s1_ch]      <= cnt[s1_ch] + 1'b1;
                    sat_seen[s1_ch] <= sat_seen[s1_ch] || over;
                end
            end
        end
    end
endmodule
